multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath: the datapath
// provides instruction and status inputs, the controller drives the strobes.
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mul_done;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        reg_write;
   logic [1:0]  reg_dst;
   logic [1:0]  wb_sel;
   logic        alu_src_imm;
   logic [1:0]  alu_op;
   logic        mem_read;
   logic        mem_write;
   logic        mul_start;
   logic        halted;
   logic [15:0] retired;

   // controller side
   modport master (
      input  instr, zero, mul_done,
      output ir_write, pc_write, pc_src, reg_write, reg_dst, wb_sel,
             alu_src_imm, alu_op, mem_read, mem_write, mul_start, halted,
             retired
   );

   // datapath side
   modport slave (
      output instr, zero, mul_done,
      input  ir_write, pc_write, pc_src, reg_write, reg_dst, wb_sel,
             alu_src_imm, alu_op, mem_read, mem_write, mul_start, halted,
             retired
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM. Outputs are decoded from the current
// state; only DECODE looks at instr directly, and the instruction class is
// latched on leaving DECODE so later states are immune to instr changes.
module multicycle_control (
   input logic                 clk,
   input logic                 reset,
   multicycle_control_if.master bus
);
   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXEC    = 3'd2;
   localparam logic [2:0] S_MEMACC  = 3'd3;
   localparam logic [2:0] S_MULWAIT = 3'd4;
   localparam logic [2:0] S_WB      = 3'd5;
   localparam logic [2:0] S_HALT    = 3'd6;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MUL   = 6'h18;

   // instruction classes that need state beyond DECODE
   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_BEQ  = 3'd1;
   localparam logic [2:0] C_ADDI = 3'd2;
   localparam logic [2:0] C_SW   = 3'd3;
   localparam logic [2:0] C_LW   = 3'd4;
   localparam logic [2:0] C_MUL  = 3'd5;

   logic [2:0]  state, next_state;
   logic [2:0]  cls, dec_cls;
   logic [3:0]  wait_cnt;
   logic [15:0] retired_q;
   logic        is_jal, is_j, is_jr;
   logic [5:0]  opcode, funct;
   logic        unused_instr_bits;

   assign opcode = bus.instr[31:26];
   assign funct  = bus.instr[5:0];
   assign unused_instr_bits = ^bus.instr[25:6];

   assign is_jal = (opcode == OP_JAL);
   assign is_j   = (opcode == OP_J);
   assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);

   // classify the instruction for the multi-state paths
   always_comb begin
      dec_cls = C_NONE;
      case (opcode)
         OP_BEQ:   dec_cls = C_BEQ;
         OP_ADDI:  dec_cls = C_ADDI;
         OP_SW:    dec_cls = C_SW;
         OP_LW:    dec_cls = C_LW;
         OP_RTYPE: if (funct == FN_MUL) dec_cls = C_MUL;
         default:  dec_cls = C_NONE;
      endcase
   end

   // next-state selection
   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            if (is_jal || is_j || is_jr) next_state = S_FETCH;
            else if (dec_cls == C_MUL)   next_state = S_MULWAIT;
            else if (dec_cls != C_NONE)  next_state = S_EXEC;
            else                         next_state = S_HALT;
         end
         S_EXEC: begin
            if (cls == C_BEQ)       next_state = S_FETCH;
            else if (cls == C_ADDI) next_state = S_WB;
            else                    next_state = S_MEMACC;
         end
         S_MEMACC:  next_state = (cls == C_LW) ? S_WB : S_FETCH;
         // done wins over timeout on the 16th wait cycle
         S_MULWAIT: begin
            if (bus.mul_done)           next_state = S_WB;
            else if (wait_cnt == 4'hF)  next_state = S_HALT;
            else                        next_state = S_MULWAIT;
         end
         S_WB:      next_state = S_FETCH;
         S_HALT:    next_state = S_HALT;
         default:   next_state = S_HALT;
      endcase
   end

   // state, latched class, wait counter and retire counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_FETCH;
         cls       <= C_NONE;
         wait_cnt  <= 4'd0;
         retired_q <= 16'd0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) cls <= dec_cls;
         // counter idles at zero so it is clear on every MULWAIT entry
         if (state == S_MULWAIT) wait_cnt <= wait_cnt + 4'd1;
         else                    wait_cnt <= 4'd0;
         if (next_state == S_FETCH) retired_q <= retired_q + 16'd1;
      end
   end

   assign bus.retired = retired_q;

   // per-state control strobes; everything defaults low
   always_comb begin
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = 2'd0;
      bus.reg_write   = 1'b0;
      bus.reg_dst     = 2'd0;
      bus.wb_sel      = 2'd0;
      bus.alu_src_imm = 1'b0;
      bus.alu_op      = 2'd0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mul_start   = 1'b0;
      bus.halted      = 1'b0;
      case (state)
         S_FETCH: begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
         end
         S_DECODE: begin
            if (is_jal) begin
               bus.pc_write  = 1'b1;
               bus.pc_src    = 2'd2;
               bus.reg_write = 1'b1;
               bus.reg_dst   = 2'd2;
               bus.wb_sel    = 2'd2;
            end else if (is_j) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = 2'd2;
            end else if (is_jr) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = 2'd3;
            end else if (dec_cls == C_MUL) begin
               bus.mul_start = 1'b1;
            end
         end
         S_EXEC: begin
            if (cls == C_BEQ) begin
               bus.alu_op = 2'd1;
               if (bus.zero) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = 2'd1;
               end
            end else begin
               bus.alu_src_imm = 1'b1;
            end
         end
         S_MEMACC: begin
            if (cls == C_LW) bus.mem_read  = 1'b1;
            else             bus.mem_write = 1'b1;
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            if (cls == C_LW) begin
               bus.wb_sel = 2'd1;
            end else if (cls == C_MUL) begin
               bus.reg_dst = 2'd1;
               bus.wb_sel  = 2'd3;
            end
         end
         S_HALT:  bus.halted = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: the stimulus walks each
// instruction through the cycle sequence its opcode calls for and queues the
// expected strobes per cycle; a negedge monitor pops and compares.
module tb_multicycle_control;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_if bus();
   multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

   localparam int K_JAL = 0, K_J = 1, K_JR = 2, K_BEQ = 3, K_ADDI = 4,
                  K_SW = 5, K_LW = 6, K_MUL = 7, K_ILL = 8;

   typedef struct {
      logic [15:0] o;
      logic [15:0] ret;
      string       tag;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] model_ret = 16'd0;
   logic [15:0] act_o;

   assign act_o = {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                   bus.reg_dst, bus.wb_sel, bus.alu_src_imm, bus.alu_op,
                   bus.mem_read, bus.mem_write, bus.mul_start, bus.halted};

   function automatic logic [15:0] mk(input logic ir, input logic pcw,
      input logic [1:0] pcs, input logic rw, input logic [1:0] rd,
      input logic [1:0] wb, input logic imm, input logic [1:0] aop,
      input logic mr, input logic mw, input logic ms, input logic h);
      return {ir, pcw, pcs, rw, rd, wb, imm, aop, mr, mw, ms, h};
   endfunction

   function automatic logic [15:0] v_fetch();
      return mk(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [15:0] v_halt();
      return mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction
   function automatic logic [15:0] v_idle();
      return 16'd0;
   endfunction
   function automatic logic [15:0] v_imm();
      return mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   // DECODE-cycle strobes implied by the opcode alone
   function automatic logic [15:0] v_decode(input int k);
      case (k)
         K_JAL: return mk(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         K_J:   return mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         K_JR:  return mk(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         K_MUL: return mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         default: return 16'd0;
      endcase
   endfunction

   // WRITEBACK strobes by instruction
   function automatic logic [15:0] v_wb(input int k);
      case (k)
         K_LW:  return mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         K_MUL: return mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         default: return mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: one expected record per clock cycle
   always @(negedge clk) begin : mon
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.tag, " strobes"}, act_o, e.o);
         chk({e.tag, " retired"}, bus.retired, e.ret);
      end
   end

   // drive one cycle's inputs, queue its expectation, advance past the edge
   task automatic cyc(input logic [31:0] i, input logic z, input logic md,
                      input logic [15:0] o, input string tag);
      exp_t e;
      bus.instr    = i;
      bus.zero     = z;
      bus.mul_done = md;
      e.o   = o;
      e.ret = model_ret;
      e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [31:0] make_instr(input int k);
      logic [31:0] w;
      logic [5:0]  op;
      w = $urandom;
      case (k)
         K_JAL:  w[31:26] = 6'h03;
         K_J:    w[31:26] = 6'h02;
         K_JR:   begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
         K_BEQ:  w[31:26] = 6'h04;
         K_ADDI: w[31:26] = 6'h08;
         K_SW:   w[31:26] = 6'h2B;
         K_LW:   w[31:26] = 6'h23;
         K_MUL:  begin w[31:26] = 6'h00; w[5:0] = 6'h18; end
         default: begin
            if (rb()) begin
               w[31:26] = 6'h00;
               while (w[5:0] == 6'h08 || w[5:0] == 6'h18) w[5:0] = 6'($urandom);
            end else begin
               op = 6'($urandom);
               while (op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 ||
                      op == 6'h08 || op == 6'h23 || op == 6'h2B) op = 6'($urandom);
               w[31:26] = op;
            end
         end
      endcase
      return w;
   endfunction

   // one instruction from FETCH to its completion; mdly = MULWAIT cycle
   // on which mul_done rises (0 = never)
   task automatic run_instr(input int k, input logic [31:0] iw, input logic z,
                            input int mdly, output logic halt_out);
      logic done;
      halt_out = 1'b0;
      cyc($urandom, rb(), rb(), v_fetch(), "fetch");
      cyc(iw, rb(), rb(), v_decode(k), "decode");
      case (k)
         K_BEQ: cyc($urandom, z, rb(),
                    mk(1'b0, z, z ? 2'd1 : 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1,
                       1'b0, 1'b0, 1'b0, 1'b0), "beq exec");
         K_ADDI: begin
            cyc($urandom, rb(), rb(), v_imm(), "addi exec");
            cyc($urandom, rb(), rb(), v_wb(k), "addi wb");
         end
         K_SW: begin
            cyc($urandom, rb(), rb(), v_imm(), "sw exec");
            cyc($urandom, rb(), rb(),
                mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), "sw mem");
         end
         K_LW: begin
            cyc($urandom, rb(), rb(), v_imm(), "lw exec");
            cyc($urandom, rb(), rb(),
                mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "lw mem");
            cyc($urandom, rb(), rb(), v_wb(k), "lw wb");
         end
         K_MUL: begin
            done = 1'b0;
            for (int c = 1; c <= 16 && !done; c++) begin
               cyc($urandom, rb(), (c == mdly), v_idle(), "mulwait");
               done = (c == mdly);
            end
            if (done) cyc($urandom, rb(), rb(), v_wb(k), "mul wb");
            else      halt_out = 1'b1;
         end
         K_ILL: halt_out = 1'b1;
         default: ;
      endcase
      if (!halt_out) model_ret = model_ret + 16'd1;
   endtask

   task automatic halt_cycles(input int n);
      for (int c = 0; c < n; c++) cyc($urandom, rb(), rb(), v_halt(), "halt");
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      chk("reset strobes", act_o, v_fetch());
      chk("reset retired", bus.retired, 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_ret = 16'd0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h;
      int   k, md, nh;
      bus.instr = 32'd0;
      bus.zero = 1'b0;
      bus.mul_done = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset strobes", act_o, v_fetch());
      chk("reset retired", bus.retired, 16'd0);
      reset = 1'b0;

      // directed sequence
      run_instr(K_ADDI, 32'h200400A1, 1'b0, 0, h);
      run_instr(K_JAL,  32'h0C00000D, 1'b0, 0, h);
      run_instr(K_JR,   32'h03E00008, 1'b0, 0, h);
      run_instr(K_BEQ,  32'h11090005, 1'b1, 0, h);
      run_instr(K_BEQ,  32'h11090005, 1'b0, 0, h);
      run_instr(K_MUL,  32'h00864018, 1'b0, 3, h);
      run_instr(K_MUL,  32'h00864018, 1'b0, 16, h);
      run_instr(K_MUL,  32'h00864018, 1'b0, 0, h);
      halt_cycles(5);
      do_reset();
      run_instr(K_ILL, 32'hFC000000, 1'b0, 0, h);
      halt_cycles(20);
      do_reset();

      // async reset in the middle of an sw memory access
      run_instr(K_LW, make_instr(K_LW), 1'b0, 0, h);
      cyc($urandom, rb(), rb(), v_fetch(), "fetch");
      cyc(32'hAC000000, rb(), rb(), v_decode(K_SW), "decode");
      cyc($urandom, rb(), rb(), v_imm(), "sw exec");
      chk("sw mem before reset", act_o,
          mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      #1;
      do_reset();

      // randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 8);
         if (k == K_ILL && $urandom_range(0, 3) != 0) k = K_ADDI;
         md = $urandom_range(0, 16);
         if (md == 0 && rb()) md = 1;
         run_instr(k, make_instr(k), rb(), md, h);
         if (h) begin
            nh = $urandom_range(3, 8);
            halt_cycles(nh);
            do_reset();
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
